// File: rtl/mac_accumulator.sv
// mac_accumulator: streaming dot-product accumulator on top of an 8x8
// unsigned multiplier. Operand beats arrive on a valid/ready handshake. Their
// products are summed until a beat marked last arrives. The sum, the beat
// count and a sticky overflow flag are then held on a single-entry output
// handshake.
// Optional feature: define MAC_ACCUMULATOR_SATURATE_EN to clamp the
// accumulator at all-ones after overflow. Without it, the accumulator wraps.

// 8x8 unsigned multiplier, purely combinational
module multiplier_fast (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

module mac_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int unsigned PROD_W = 16;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                accept_c;
  logic [PROD_W-1:0]   prod_c;
  logic [PROD_W-1:0]   p1;
  logic                p1_valid;
  logic                p1_last;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  logic [SUM_W-1:0]    sum_c;
  logic                ovf_c;
  logic [ACC_W-1:0]    acc_next_c;

  assign accept_c = in_valid && in_ready;

  multiplier_fast u_mul (
    .a (in_a),
    .b (in_b),
    .p (prod_c)
  );

  // Next-state logic for the accumulate / drain / hold sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept_c && in_last) state_d = DRAIN;
      DRAIN:   state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // State register; in_ready is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCUM;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == ACCUM);
    end
  end

  // Stage 1: capture the product of each accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      p1       <= '0;
      p1_last  <= 1'b0;
      p1_valid <= 1'b0;
    end else begin
      p1_valid <= accept_c;
      if (accept_c) begin
        p1      <= prod_c;
        p1_last <= in_last;
      end
    end
  end

  // Stage 2 adder with the carry out kept to detect overflow
  always_comb begin
    sum_c = {1'b0, acc} + SUM_W'(p1);
    ovf_c = sum_c[ACC_W] | ovf;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    acc_next_c = ovf_c ? '1 : sum_c[ACC_W-1:0];
`else
    acc_next_c = sum_c[ACC_W-1:0];
`endif
  end

  // Accumulator, beat counter and sticky overflow; all clear at end of vector
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (accept_c) cnt <= cnt + CNT_W'(1);
      if (p1_valid) begin
        if (p1_last) begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end else begin
          acc <= acc_next_c;
          ovf <= ovf_c;
        end
      end
    end
  end

  // Result registers: loaded by the last beat, released by out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (p1_valid && p1_last) begin
      out_valid <= 1'b1;
      out_sum   <= acc_next_c;
      out_count <= cnt;
      out_ovf   <= ovf_c;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator. It uses a default-width instance and an
// ACC_W=16 instance. Both instances share the input stimulus and run in lockstep.
`timescale 1ns/1ps
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_sum;
  logic [8:0]  out_count;
  logic        out_ovf;

  logic        n_in_ready;
  logic        n_out_valid;
  logic [15:0] n_out_sum;
  logic [8:0]  n_out_count;
  logic        n_out_ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  mac_accumulator #(.ACC_W(16), .CNT_W(9)) dut_n (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_sum(n_out_sum), .out_count(n_out_count), .out_ovf(n_out_ovf)
  );

  // Advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle (caller ensures in_ready=1)
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Consume the held result
  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_sum !== 24'd0 || out_count !== 9'd0 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%0b sum=%0d cnt=%0d ovf=%0b, want 0/0/0/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    beat(8'd5, 8'd10, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: got valid=%0b ready=%0b want 0/0", out_valid, in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'd50 || out_count !== 9'd1 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_result: got valid=%0b sum=%0d cnt=%0d ovf=%0b want 1/50/1/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    release_out();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_release: got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_four();
    logic [7:0] av [4] = '{8'd1, 8'd15, 8'd127, 8'd255};
    logic [7:0] bv [4] = '{8'd255, 8'd15, 8'd2, 8'd255};
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL four_in_ready[%0d]: got %0b want 1", i, in_ready);
      end
      beat(av[i], bv[i], i == 3);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'd65759 || out_count !== 9'd4 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL four_result: got valid=%0b sum=%0d cnt=%0d ovf=%0b want 1/65759/4/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    beat(8'd3, 8'd3, 1'b1);
    tick();
    // Unaccepted garbage on the input must be ignored while holding
    in_valid = 1'b1; in_a = 8'hff; in_b = 8'hff; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_sum !== 24'd9 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got valid=%0b sum=%0d ready=%0b want 1/9/0",
                 i, out_valid, out_sum, in_ready);
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_out();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_long();
    for (int i = 0; i < 256; i++) beat(8'd255, 8'd255, i == 255);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'd16646400 || out_count !== 9'd256 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL long_result: got valid=%0b sum=%0d cnt=%0d ovf=%0b want 1/16646400/256/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    release_out();
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 512; i++) beat(8'd1, 8'd1, i == 511);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'd512 || out_count !== 9'd0 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL count_wrap: got valid=%0b sum=%0d cnt=%0d ovf=%0b want 1/512/0/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    release_out();
  endtask

  task automatic test_overflow();
    logic [15:0] exp_n;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    exp_n = 16'd65535;
`else
    exp_n = 16'd64514;
`endif
    beat(8'd255, 8'd255, 1'b0);
    beat(8'd255, 8'd255, 1'b1);
    tick();
    tests_run++;
    if (n_out_valid !== 1'b1 || n_out_sum !== exp_n || n_out_count !== 9'd2 || n_out_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL narrow_ovf: got valid=%0b sum=%0d cnt=%0d ovf=%0b want 1/%0d/2/1",
               n_out_valid, n_out_sum, n_out_count, n_out_ovf, exp_n);
    end
    tests_run++;
    if (out_sum !== 24'd130050 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL wide_no_ovf: got sum=%0d ovf=%0b want 130050/0", out_sum, out_ovf);
    end
    release_out();
    // Sticky flag must not leak into the next vector
    beat(8'd2, 8'd2, 1'b1);
    tick();
    tests_run++;
    if (n_out_sum !== 16'd4 || n_out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL narrow_ovf_clear: got sum=%0d ovf=%0b want 4/0", n_out_sum, n_out_ovf);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    beat(8'd7, 8'd7, 1'b0);
    beat(8'd8, 8'd8, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat(8'd3, 8'd3, 1'b1);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'd9 || out_count !== 9'd1 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got valid=%0b sum=%0d cnt=%0d ovf=%0b want 1/9/1/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    // Reset while holding drops the result without a handshake
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_sum !== 24'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_hold: got valid=%0b sum=%0d ready=%0b want 0/0/1",
               out_valid, out_sum, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    beat(8'd4, 8'd4, 1'b1);
    tick();
    release_out();
    beat(8'd6, 8'd6, 1'b0);
    beat(8'd1, 8'd2, 1'b1);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'd38 || out_count !== 9'd2) begin
      tests_failed++;
      $display("FAIL back_to_back: got valid=%0b sum=%0d cnt=%0d want 1/38/2",
               out_valid, out_sum, out_count);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_backpressure();
    test_long();
    test_count_wrap();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
